multicycle_control: RTL and testbench

- Main control unit for the multicycle CPU datapath.
- Decodes the instruction opcode and steps through fetch / decode / execute / memory / writeback states.
- Drives every datapath mux-select and write-enable each cycle.
- Waits on a memory-ready handshake in the memory-access states, and flags unsupported opcodes.

---
 rtl/multicycle_control_pkg.sv | 72 +++++++
 rtl/multicycle_control_if.sv | 44 ++++
 rtl/multicycle_control_decode.sv | 92 +++++++++
 rtl/multicycle_control.sv | 106 ++++++++++
 tb/tb_multicycle_control.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared CPU definitions for the multicycle datapath, the control unit and
//   the testbench.
//   Contents: opcode constants, state encodings, ALU/mux select encodings, the
//   packed control word that the decode stage produces, and an opcode helper.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control-unit states; codes 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11
    } state_e;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Loads and stores share the address-calculation state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Bundle between the control unit and the datapath.
//   master (control unit): in  opcode, mem_ready
//                          out all mux selects / write enables, illegal_op,
//                              state
//   slave  (datapath/TB) : the reverse direction of every signal.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int OPCODE_SIZE = 6,
    parameter int STATE_SIZE  = 4
);
    logic [OPCODE_SIZE-1:0] opcode;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic                   i_or_d;
    logic                   mem_read;
    logic                   mem_write;
    logic                   ir_write;
    logic                   mem_to_reg;
    logic                   reg_dst;
    logic                   reg_write;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             alu_op;
    logic [1:0]             pc_source;
    logic                   illegal_op;
    logic [STATE_SIZE-1:0]  state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// ---------------------------------------------------------------------------
// multicycle_control_decode
//   Purely combinational state -> control-word decode (Moore), with the
//   FETCH strobes qualified by mem_ready.
//   Ports: state     (in)  current state code
//          mem_ready (in)  memory handshake
//          ctrl      (out) control word for this cycle
// ---------------------------------------------------------------------------
module multicycle_control_decode
    import multicycle_control_pkg::*;
#(
    parameter int STATE_SIZE = 4
) (
    input  logic [STATE_SIZE-1:0] state,
    input  logic                  mem_ready,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load once the instruction word has arrived
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_dst    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_dst    = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main sequencer of the multicycle CPU: steps fetch/decode/execute/memory/
//   writeback, holds the opcode latched in DECODE and the sticky illegal_op
//   flag, and drives all datapath controls through the decode sub-module.
//   Ports: clk   (in)  rising-edge clock
//          reset (in)  asynchronous, active-low reset
//          bus   (master modport) opcode/mem_ready in, controls/state out
// ---------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_SIZE = 6,
    parameter int STATE_SIZE  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        bus
);

    logic [STATE_SIZE-1:0]  state_q, state_d;
    logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
    logic                   illegal_q, illegal_d;
    ctrl_t                  ctrl;

    // State, latched opcode and sticky illegal flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STATE_SIZE'(ST_FETCH);
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; the opcode is captured only in DECODE so later
    // changes on the IR bits cannot redirect MEMADR
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) state_d = STATE_SIZE'(ST_DECODE);
            end
            ST_DECODE: begin
                opcode_d = bus.opcode;
                if (is_mem_op(bus.opcode))         state_d = STATE_SIZE'(ST_MEMADR);
                else if (bus.opcode == OP_RTYPE)   state_d = STATE_SIZE'(ST_EXECUTE);
                else if (bus.opcode == OP_BEQ)     state_d = STATE_SIZE'(ST_BRANCH);
                else if (bus.opcode == OP_ADDI)    state_d = STATE_SIZE'(ST_ADDIEX);
                else if (bus.opcode == OP_J)       state_d = STATE_SIZE'(ST_JUMP);
                else begin
                    state_d   = STATE_SIZE'(ST_FETCH);
                    illegal_d = 1'b1;
                end
            end
            ST_MEMADR: begin
                state_d = (opcode_q == OP_LW) ? STATE_SIZE'(ST_MEMRD)
                                              : STATE_SIZE'(ST_MEMWR);
            end
            ST_MEMRD: begin
                if (bus.mem_ready) state_d = STATE_SIZE'(ST_MEMWB);
            end
            ST_MEMWB:   state_d = STATE_SIZE'(ST_FETCH);
            ST_MEMWR: begin
                if (bus.mem_ready) state_d = STATE_SIZE'(ST_FETCH);
            end
            ST_EXECUTE: state_d = STATE_SIZE'(ST_ALUWB);
            ST_ALUWB:   state_d = STATE_SIZE'(ST_FETCH);
            ST_BRANCH:  state_d = STATE_SIZE'(ST_FETCH);
            ST_JUMP:    state_d = STATE_SIZE'(ST_FETCH);
            ST_ADDIEX:  state_d = STATE_SIZE'(ST_ADDIWB);
            ST_ADDIWB:  state_d = STATE_SIZE'(ST_FETCH);
            default:    state_d = STATE_SIZE'(ST_FETCH);
        endcase
    end

    multicycle_control_decode #(
        .STATE_SIZE (STATE_SIZE)
    ) u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = illegal_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed, self-checking bench for the multicycle control unit. Inputs
//   change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return to the sampling point
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = OP_RTYPE;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: state=%0d illegal=%b, want 0/0", bus.state, bus.illegal_op);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 ||
                bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_fetch[%0d]: state=%0d rd=%b ir=%b pcw=%b, want 0/1/0/0",
                         i, bus.state, bus.mem_read, bus.ir_write, bus.pc_write);
            end
        end
        // Leave FETCH, then pull reset between edges
        bus.mem_ready = 1'b1;
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL fetch_to_decode: state=%0d, want 1", bus.state);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: state=%0d, want 0", bus.state);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lw();
        int exp_st [6] = '{0, 1, 2, 3, 4, 0};
        $display("[TB] test_lw");
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_LW;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++;
                $display("[TB] FAIL lw_state[%0d]: state=%0d, want %0d", i, bus.state, exp_st[i]);
            end
            if (i == 0) begin
                checks++;
                if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lw_fetch_strobes: ir=%b pcw=%b, want 1/1", bus.ir_write, bus.pc_write);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL lw_memadr: srca=%b srcb=%b, want 1/10", bus.alu_src_a, bus.alu_src_b);
                end
                bus.opcode = OP_RTYPE;
            end
            if (i == 3) begin
                checks++;
                if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lw_memrd: rd=%b iord=%b, want 1/1", bus.mem_read, bus.i_or_d);
                end
            end
            if (i == 4) begin
                checks++;
                if (bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.reg_dst !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lw_memwb: rw=%b m2r=%b dst=%b, want 1/1/0",
                             bus.reg_write, bus.mem_to_reg, bus.reg_dst);
                end
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_sw_wait();
        int   exp_st [7] = '{0, 1, 2, 5, 5, 5, 0};
        logic mr     [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   wr_cycles = 0;
        $display("[TB] test_sw_wait");
        bus.opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = mr[i];
            #1;
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++;
                $display("[TB] FAIL sw_state[%0d]: state=%0d, want %0d", i, bus.state, exp_st[i]);
            end
            if (bus.mem_write === 1'b1) wr_cycles++;
            checks++;
            if (bus.mem_write === 1'b1 && bus.mem_read !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sw_rd_wr_overlap[%0d]: rd=%b wr=%b, want not both", i, bus.mem_read, bus.mem_write);
            end
            if (i < 6) step();
        end
        checks++;
        if (wr_cycles != 3) begin
            errors++;
            $display("[TB] FAIL sw_write_cycles: got %0d, want 3", wr_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int         exp_st [11] = '{0, 1, 6, 7, 0, 1, 8, 0, 1, 9, 0};
        logic [5:0] ops    [3]  = '{OP_RTYPE, OP_BEQ, OP_J};
        int         instr       = 0;
        $display("[TB] test_back_to_back");
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (bus.state === 4'd0 && instr < 3) begin
                bus.opcode = ops[instr];
                instr++;
            end
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++;
                $display("[TB] FAIL b2b_state[%0d]: state=%0d, want %0d", i, bus.state, exp_st[i]);
            end
            checks++;
            if (bus.reg_write === 1'b1 && bus.pc_write === 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_rw_pcw[%0d]: rw=%b pcw=%b, want not both", i, bus.reg_write, bus.pc_write);
            end
            if (exp_st[i] == 6) begin
                checks++;
                if (bus.alu_op !== 2'b10 || bus.alu_src_b !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL rtype_exec: aluop=%b srcb=%b, want 10/00", bus.alu_op, bus.alu_src_b);
                end
            end
            if (exp_st[i] == 7) begin
                checks++;
                if (bus.reg_dst !== 1'b1 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rtype_aluwb: dst=%b rw=%b m2r=%b, want 1/1/0",
                             bus.reg_dst, bus.reg_write, bus.mem_to_reg);
                end
            end
            if (exp_st[i] == 8) begin
                checks++;
                if (bus.pc_write_cond !== 1'b1 || bus.alu_op !== 2'b01 ||
                    bus.pc_source !== 2'b01 || bus.pc_write !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL beq_branch: pwc=%b aluop=%b pcsrc=%b pcw=%b, want 1/01/01/0",
                             bus.pc_write_cond, bus.alu_op, bus.pc_source, bus.pc_write);
                end
            end
            if (exp_st[i] == 9) begin
                checks++;
                if (bus.pc_write !== 1'b1 || bus.pc_source !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL j_jump: pcw=%b pcsrc=%b, want 1/10", bus.pc_write, bus.pc_source);
                end
            end
            if (i < 10) step();
        end
    endtask

    task automatic test_addi();
        int exp_st [5] = '{0, 1, 10, 11, 0};
        $display("[TB] test_addi");
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_ADDI;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++;
                $display("[TB] FAIL addi_state[%0d]: state=%0d, want %0d", i, bus.state, exp_st[i]);
            end
            if (i == 1) begin
                checks++;
                if (bus.alu_src_b !== 2'b11 || bus.alu_src_a !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL decode_target: srcb=%b srca=%b, want 11/0", bus.alu_src_b, bus.alu_src_a);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.alu_src_b !== 2'b10 || bus.alu_src_a !== 1'b1 || bus.reg_write !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL addi_ex: srcb=%b srca=%b rw=%b, want 10/1/0",
                             bus.alu_src_b, bus.alu_src_a, bus.reg_write);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL addi_wb: rw=%b dst=%b m2r=%b, want 1/0/0",
                             bus.reg_write, bus.reg_dst, bus.mem_to_reg);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_illegal();
        int exp_st [5] = '{1, 2, 3, 4, 0};
        $display("[TB] test_illegal");
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b111111;
        step();
        checks++;
        if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_decode: state=%0d illegal=%b, want 1/0", bus.state, bus.illegal_op);
        end
        step();
        checks++;
        if (bus.state !== 4'd0 || bus.illegal_op !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_set: state=%0d illegal=%b, want 0/1", bus.state, bus.illegal_op);
        end
        bus.opcode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.state !== 4'(exp_st[i]) || bus.illegal_op !== 1'b1) begin
                errors++;
                $display("[TB] FAIL illegal_sticky[%0d]: state=%0d illegal=%b, want %0d/1",
                         i, bus.state, bus.illegal_op, exp_st[i]);
            end
        end
        // Reset mid-instruction: go to MEMADR, then reset
        step();
        step();
        checks++;
        if (bus.state !== 4'd2) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: state=%0d, want 2", bus.state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.illegal_op !== 1'b0 || bus.state !== 4'd0 || bus.reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_clear: illegal=%b state=%0d rw=%b, want 0/0/0",
                     bus.illegal_op, bus.state, bus.reg_write);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL restart_fetch: state=%0d, want 1", bus.state);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_addi();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
